// File: rtl/cpu_control.sv
// Control unit for the 16-bit RISC processor: a one-hot Moore FSM that fetches,
// decodes and sequences every datapath, PC and memory control signal.
module cpu_control (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instr,
  input  logic [2:0]  ZVN,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [3:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        load_ir,
  output logic        load_pc,
  output logic        reset_pc,
  output logic        load_addr,
  output logic        addr_sel,
  output logic [1:0]  pc_sel,
  output logic [1:0]  mem_cmd,
  output logic        halted
);

  typedef enum logic [18:0] {
    S_RST      = 19'h00001,
    S_IF1      = 19'h00002,
    S_IF2      = 19'h00004,
    S_UPD_PC   = 19'h00008,
    S_DECODE   = 19'h00010,
    S_WR_IMM   = 19'h00020,
    S_GET_A    = 19'h00040,
    S_GET_B    = 19'h00080,
    S_EXEC     = 19'h00100,
    S_WR_REG   = 19'h00200,
    S_MEM_ADDR = 19'h00400,
    S_LD_ADDR  = 19'h00800,
    S_MEM_RD   = 19'h01000,
    S_LDR_WB   = 19'h02000,
    S_STR_B    = 19'h04000,
    S_STR_PASS = 19'h08000,
    S_MEM_WR   = 19'h10000,
    S_BRANCH   = 19'h20000,
    S_HALT     = 19'h40000
  } state_e;

  state_e state_q, state_d;

  logic [2:0] opcode_s, rn_s, rd_s, rm_s;
  logic [1:0] op_s, sh_s;
  logic       is_mem_s, is_ldr_s, is_cmp_s, is_mov_reg_s;
  logic       flag_z_s, flag_v_s, flag_n_s, taken_s;

  assign opcode_s = instr[15:13];
  assign op_s     = instr[12:11];
  assign rn_s     = instr[10:8];
  assign rd_s     = instr[7:5];
  assign sh_s     = instr[4:3];
  assign rm_s     = instr[2:0];

  assign sximm8 = {{8{instr[7]}}, instr[7:0]};
  assign sximm5 = {{11{instr[4]}}, instr[4:0]};

  // The IR is stable after IF2, so later states re-derive the instruction class from it.
  assign is_ldr_s     = (opcode_s == 3'b011);
  assign is_mem_s     = (opcode_s == 3'b011) || (opcode_s == 3'b100);
  assign is_mov_reg_s = (opcode_s == 3'b110);
  assign is_cmp_s     = (opcode_s == 3'b101) && (op_s == 2'b01);

  assign flag_z_s = ZVN[2];
  assign flag_v_s = ZVN[1];
  assign flag_n_s = ZVN[0];

  // Branch condition evaluation from the status flags.
  always_comb begin
    taken_s = 1'b0;
    case (rn_s)
      3'b000:  taken_s = 1'b1;
      3'b001:  taken_s = flag_z_s;
      3'b010:  taken_s = !flag_z_s;
      3'b011:  taken_s = (flag_n_s != flag_v_s);
      3'b100:  taken_s = (flag_n_s != flag_v_s) || flag_z_s;
      default: taken_s = 1'b0;
    endcase
  end

  // State register; reset takes effect immediately, even mid-instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_IF1;
      S_IF1:    state_d = S_IF2;
      S_IF2:    state_d = S_UPD_PC;
      S_UPD_PC: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode_s)
          3'b110: begin
            if (op_s == 2'b10) begin
              state_d = S_WR_IMM;
            end else if (op_s == 2'b00) begin
              state_d = S_GET_A;
            end else begin
              state_d = S_IF1;
            end
          end
          3'b101:  state_d = S_GET_A;
          3'b011:  state_d = (op_s == 2'b00) ? S_GET_A : S_IF1;
          3'b100:  state_d = (op_s == 2'b00) ? S_GET_A : S_IF1;
          3'b001:  state_d = (op_s == 2'b00) ? S_BRANCH : S_IF1;
          3'b111:  state_d = S_HALT;
          default: state_d = S_IF1;
        endcase
      end
      S_WR_IMM:   state_d = S_IF1;
      S_GET_A:    state_d = is_mem_s ? S_MEM_ADDR : S_GET_B;
      S_GET_B:    state_d = S_EXEC;
      S_EXEC:     state_d = is_cmp_s ? S_IF1 : S_WR_REG;
      S_WR_REG:   state_d = S_IF1;
      S_MEM_ADDR: state_d = S_LD_ADDR;
      S_LD_ADDR:  state_d = is_ldr_s ? S_MEM_RD : S_STR_B;
      S_MEM_RD:   state_d = S_LDR_WB;
      S_LDR_WB:   state_d = S_IF1;
      S_STR_B:    state_d = S_STR_PASS;
      S_STR_PASS: state_d = S_MEM_WR;
      S_MEM_WR:   state_d = S_IF1;
      S_BRANCH:   state_d = S_IF1;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_RST;
    endcase
  end

  // Moore output decode; everything defaults to inactive.
  always_comb begin
    readnum   = 3'b000;
    writenum  = 3'b000;
    vsel      = 4'b0000;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    write     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    shift     = 2'b00;
    ALUop     = 2'b00;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    load_addr = 1'b0;
    addr_sel  = 1'b0;
    pc_sel    = 2'b00;
    mem_cmd   = 2'b00;
    halted    = 1'b0;
    case (state_q)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = 2'b01;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = 2'b01;
        load_ir  = 1'b1;
      end
      S_UPD_PC: load_pc = 1'b1;
      S_DECODE: ;
      S_WR_IMM: begin
        writenum = rn_s;
        vsel     = 4'b0100;
        write    = 1'b1;
      end
      S_GET_A: begin
        readnum = rn_s;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm_s;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        shift = sh_s;
        loadc = 1'b1;
        if (is_mov_reg_s) begin
          asel  = 1'b1;
          ALUop = 2'b00;
        end else begin
          ALUop = op_s;
          loads = is_cmp_s;
        end
      end
      S_WR_REG: begin
        writenum = rd_s;
        vsel     = 4'b0001;
        write    = 1'b1;
      end
      S_MEM_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_LD_ADDR: load_addr = 1'b1;
      S_MEM_RD:  mem_cmd = 2'b01;
      S_LDR_WB: begin
        mem_cmd  = 2'b01;
        vsel     = 4'b1000;
        writenum = rd_s;
        write    = 1'b1;
      end
      S_STR_B: begin
        readnum = rd_s;
        loadb   = 1'b1;
      end
      S_STR_PASS: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_MEM_WR: mem_cmd = 2'b10;
      S_BRANCH: begin
        load_pc = taken_s;
        pc_sel  = 2'b01;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/cpu_control.md
# cpu_control

Control unit for the 16-bit RISC processor: the sequencing end of the datapath control interface. It decodes the instruction register contents and drives every datapath control input (register file, A/B/C/status loads, operand selects, shift, ALU op, writeback mux) cycle by cycle. It also drives the program counter and the memory command and address controls for fetch, load and store. It sits between the instruction register/PC/memory glue and the datapath, and is a Moore FSM with one-hot state register.

## Interface
- No parameters. Widths are fixed by the ISA: 16-bit instruction, 3-bit register numbers, 9-bit PC.
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr  in  16  instruction register contents; stable from the cycle after load_ir.
- ZVN  in  3  status register output, {Z,V,N}.
- readnum, writenum  out  3  register file read and write selects.
- vsel  out  4  one-hot writeback select: [3] mdata, [2] sximm8, [1] PC, [0] C.
- loada, loadb, loadc, loads, write  out  1  datapath load and write enables.
- asel, bsel  out  1  asel=1 forces A operand to 0; bsel=1 selects sximm5.
- shift, ALUop  out  2  shift: 00 none, 01 LSL1, 10 LSR1, 11 ASR1. ALUop: 00 ADD, 01 SUB, 10 AND, 11 NOT B.
- sximm8, sximm5  out  16  sign-extended instr[7:0] and instr[4:0] (combinational).
- load_ir, load_pc, reset_pc, load_addr, addr_sel  out  1  IR, PC and data-address register controls. addr_sel=1 puts PC on the memory address, 0 puts the data address register there.
- pc_sel  out  2  PC next value: 00 PC+1, 01 PC+1+sximm8 (10 and 11 reserved, never driven).
- mem_cmd  out  2  00 none, 01 read, 10 write.
- halted  out  1  high while in HALT.

## Operation
- Fields: opcode=instr[15:13], op=instr[12:11], Rn=[10:8], Rd=[7:5], sh=[4:3], Rm=[2:0], cond=[10:8].
- Every output not listed for a state is 0. Exception: shift and ALUop are 00 unless listed.
- RST: reset_pc=1, load_pc=1 -> IF1.
- IF1: addr_sel=1, mem_cmd=01 -> IF2.
- IF2: addr_sel=1, mem_cmd=01, load_ir=1 -> UPDATE_PC.
- UPDATE_PC: load_pc=1, pc_sel=00 -> DECODE.
- DECODE: no outputs. Dispatch on opcode/op:
  - 110/10 MOV Rn,#imm8 -> WR_IMM: writenum=Rn, vsel=0100, write=1 -> IF1.
  - 110/00 MOV Rd,Rm{,sh} and 101/xx ALU ops -> GET_A -> GET_B -> EXEC -> WR_REG -> IF1.
    - GET_A: readnum=Rn, loada=1.
    - GET_B: readnum=Rm, loadb=1.
    - EXEC: shift=sh, loadc=1. For MOV: asel=1, ALUop=00. For ALU ops: ALUop=op, and loads=1 only for CMP (op=01).
    - CMP goes EXEC -> IF1, with no WR_REG.
    - WR_REG: writenum=Rd, vsel=0001, write=1.
  - 011/00 LDR Rd,[Rn,#imm5] -> GET_A -> MEM_ADDR -> LD_ADDR -> MEM_RD -> LDR_WB -> IF1.
    - MEM_ADDR: bsel=1, ALUop=00, loadc=1.
    - LD_ADDR: load_addr=1.
    - MEM_RD: addr_sel=0, mem_cmd=01.
    - LDR_WB: mem_cmd=01, vsel=1000, writenum=Rd, write=1.
  - 100/00 STR Rd,[Rn,#imm5] -> GET_A -> MEM_ADDR -> LD_ADDR -> STR_B -> STR_PASS -> MEM_WR -> IF1.
    - STR_B: readnum=Rd, loadb=1.
    - STR_PASS: asel=1, ALUop=00, loadc=1.
    - MEM_WR: mem_cmd=10, addr_sel=0. Write data is datapath_out.
  - 001/00 branch -> BRANCH: load_pc=taken, pc_sel=01 -> IF1.
    - Taken conditions by cond: 000 always; 001 Z; 010 !Z; 011 N!=V; 100 (N!=V)|Z; others never.
  - 111/xx -> HALT: halted=1; remains there until reset.
  - Any other encoding is a no-op -> IF1.
- sximm8 = {{8{instr[7]}},instr[7:0]}; sximm5 = {{11{instr[4]}},instr[4:0]}.
- ZVN is sampled only in BRANCH. Flags come from the most recent CMP (loads only on CMP).

## Timing
- Reset: reset_n low forces state RST immediately, asynchronously, including mid-instruction.
  - While reset_n is low, outputs are: reset_pc=1, load_pc=1, pc_sel=00, everything else 0 (mem_cmd=00, write=0, halted=0).
  - After the first rising clk with reset_n high, the state is IF1.
- Memory reads have one cycle of latency: data is valid in the cycle after mem_cmd=01 is first issued with a stable address. This is why IF2 and LDR_WB repeat the read command.
- Cycle counts, IF1 through the last state inclusive (fetch+decode = 4):
  - MOV imm 5; MOV reg / ALU 8; CMP 7; LDR 9; STR 10; branch 5; no-op 4.
- A register written in WR_REG, WR_IMM or LDR_WB is readable from the next instruction's GET_A.
- write and mem_cmd=10 are each asserted for exactly one cycle per instruction.

## Test plan
- Reset mid-STR: pulse reset_n low during MEM_WR -> mem_cmd drops to 00 in the same cycle. After release: one RST cycle (reset_pc=1), then IF1 with addr_sel=1, mem_cmd=01.
- MOV R0,#-5 (0xD0FB) -> in cycle 5: write=1, writenum=0, vsel=0100, sximm8=0xFFFB. Next cycle is IF1.
- ADD R2,R1,R0,LSL#1 (0xA148) -> GET_A readnum=1; GET_B readnum=0; EXEC shift=01, ALUop=00, loads=0; WR_REG writenum=2, vsel=0001. 8 cycles total.
- CMP then BEQ +3 (0x2103):
  - With ZVN=100 -> BRANCH load_pc=1, pc_sel=01.
  - With ZVN=000 -> load_pc=0.
  - BLT (0x2303) with ZVN=001 -> taken.
- LDR R3,[R1,#4] (0x6164) -> MEM_ADDR bsel=1, sximm5=0x0004; LD_ADDR load_addr=1; MEM_RD mem_cmd=01, addr_sel=0; LDR_WB vsel=1000, writenum=3, write=1. 9 cycles.
- HALT (0xE000) -> halted=1 and mem_cmd=00 for 20+ cycles. reset_n low clears halted immediately.
